// File: rtl/ghost_position_update.sv
// Ghost position registers, pen release sequence and pacman contact detection.
// Latency: every output is registered and changes on the edge after an effective move tick or a contact.
// Backpressure: none; pause freezes all state and drops move_tick pulses rather than queuing them.
module ghost_position_update #(
    parameter int START_X       = 320,
    parameter int START_Y       = 240,
    parameter int EXIT_Y        = 208,
    parameter int TILE_LOG2     = 4,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 624,
    parameter int RELEASE_TICKS = 120,
    parameter int HIT_DIST      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_tick,
    input  logic        pause,
    input  logic [3:0]  move_direction,
    input  logic [10:0] pacman_pos_x,
    input  logic [9:0]  pacman_pos_y,
    output logic [10:0] ghost_pos_x,
    output logic [9:0]  ghost_pos_y,
    output logic [3:0]  curr_direction,
    output logic        ghost_active,
    output logic        caught
);

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b1000;

    localparam int CNT_W = (RELEASE_TICKS > 1) ? $clog2(RELEASE_TICKS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RELEASE_TICKS - 1);
    localparam logic [10:0]      START_XV  = 11'(START_X);
    localparam logic [9:0]       START_YV  = 10'(START_Y);
    localparam logic [9:0]       EXIT_YV   = 10'(EXIT_Y);
    localparam logic [10:0]      X_MINV    = 11'(X_MIN);
    localparam logic [10:0]      X_MAXV    = 11'(X_MAX);
    localparam logic [10:0]      HIT_XV    = 11'(HIT_DIST);
    localparam logic [9:0]       HIT_YV    = 10'(HIT_DIST);

    typedef enum logic [1:0] {
        HOME_WAIT = 2'd0,
        EXIT_PEN  = 2'd1,
        ROAM      = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [10:0]      x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic [3:0]       dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             caught_q, caught_d;

    logic        tick_en;
    logic        aligned;
    logic        md_onehot;
    logic [3:0]  new_dir;
    logic [10:0] dx;
    logic [9:0]  dy;
    logic        hit;
    logic [9:0]  y_dec;

    assign tick_en   = move_tick & ~pause;
    assign aligned   = ~|x_q[TILE_LOG2-1:0] & ~|y_q[TILE_LOG2-1:0];
    assign md_onehot = (move_direction != DIR_NONE) &&
                       ((move_direction & (move_direction - 4'd1)) == DIR_NONE);
    // Direction may only change on a tile boundary; between tiles the ghost coasts.
    assign new_dir   = aligned ? (md_onehot ? move_direction : DIR_NONE) : dir_q;
    assign dx        = (x_q >= pacman_pos_x) ? (x_q - pacman_pos_x) : (pacman_pos_x - x_q);
    assign dy        = (y_q >= pacman_pos_y) ? (y_q - pacman_pos_y) : (pacman_pos_y - y_q);
    assign hit       = ~pause && (dx < HIT_XV) && (dy < HIT_YV);
    assign y_dec     = y_q - 10'd1;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        caught_d = 1'b0;

        case (state_q)
            HOME_WAIT: begin
                if (tick_en) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = EXIT_PEN;
                        dir_d   = DIR_UP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            EXIT_PEN: begin
                if (tick_en) begin
                    y_d = y_dec;
                    if (y_dec == EXIT_YV) begin
                        state_d  = ROAM;
                        dir_d    = DIR_LEFT;
                        active_d = 1'b1;
                    end
                end
            end

            ROAM: begin
                // Contact wins over a step in the same cycle.
                if (hit) begin
                    caught_d = 1'b1;
                    x_d      = START_XV;
                    y_d      = START_YV;
                    dir_d    = DIR_NONE;
                    cnt_d    = '0;
                    active_d = 1'b0;
                    state_d  = HOME_WAIT;
                end else if (tick_en) begin
                    dir_d = new_dir;
                    case (new_dir)
                        DIR_RIGHT: x_d = (x_q == X_MAXV) ? X_MINV : x_q + 11'd1;
                        DIR_LEFT:  x_d = (x_q == X_MINV) ? X_MAXV : x_q - 11'd1;
                        DIR_UP:    y_d = y_dec;
                        DIR_DOWN:  y_d = y_q + 10'd1;
                        default:   ;
                    endcase
                end
            end

            default: begin
                state_d = HOME_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HOME_WAIT;
            x_q      <= START_XV;
            y_q      <= START_YV;
            dir_q    <= DIR_NONE;
            cnt_q    <= '0;
            active_q <= 1'b0;
            caught_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            caught_q <= caught_d;
        end
    end

    assign ghost_pos_x    = x_q;
    assign ghost_pos_y    = y_q;
    assign curr_direction = dir_q;
    assign ghost_active   = active_q;
    assign caught         = caught_q;

endmodule

// File: doc/ghost_position_update.md
Name: ghost_position_update

Overview:
- Downstream consumer of the ghost direction controller. Owns the ghost's pixel position registers and the pen-release sequence.
- On each movement tick it advances the ghost one pixel along the latched direction and detects contact with pacman.
- Feeds ghost_pos_x/ghost_pos_y and curr_direction back to the controller as its current-position and previous-direction inputs.

Parameters:
- START_X, 320: pen x (tile aligned).
- START_Y, 240: pen y (tile aligned).
- EXIT_Y, 208: maze-entry row above the pen door (tile aligned, less than START_Y).
- TILE_LOG2, 4: tile size is 2**TILE_LOG2 pixels.
- X_MIN, 0: leftmost x of the tunnel row.
- X_MAX, 624: rightmost x of the tunnel row (tile aligned).
- RELEASE_TICKS, 120: ticks spent in the pen before exit (must be at least 1).
- HIT_DIST, 8: contact threshold in pixels, per axis.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- move_tick  in  1  single-cycle movement strobe (one ghost step)
- pause  in  1  freezes movement, counters and collision
- move_direction  in  4  one-hot request from the controller: RIGHT=0001, UP=0010, DOWN=0100, LEFT=1000
- pacman_pos_x  in  11  pacman x
- pacman_pos_y  in  10  pacman y
- ghost_pos_x  out  11  registered ghost x
- ghost_pos_y  out  10  registered ghost y
- curr_direction  out  4  registered latched direction, fed back as the controller's prev_direction
- ghost_active  out  1  high only in ROAM
- caught  out  1  one-cycle pulse on contact

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, applied on the clk edge. It takes effect at the next edge, including mid-operation.
- Reset values:
  - state = HOME_WAIT
  - ghost_pos_x = START_X, ghost_pos_y = START_Y
  - curr_direction = 0000
  - release counter = 0
  - ghost_active = 0, caught = 0
- Effective tick: tick_en = move_tick & ~pause. All updates happen on the clk edge of a tick_en cycle, so outputs change one cycle after the strobe.
- States: HOME_WAIT, EXIT_PEN, ROAM.
- HOME_WAIT:
  - Position holds at START; curr_direction = 0000.
  - On each tick_en the counter increments.
  - On the tick_en where counter == RELEASE_TICKS-1: counter <= 0, state <= EXIT_PEN, curr_direction <= UP.
- EXIT_PEN:
  - Each tick_en: y <= y-1; move_direction is ignored.
  - On the tick_en where y-1 == EXIT_Y: state <= ROAM, curr_direction <= LEFT, ghost_active <= 1 at the same edge.
- ROAM:
  - Aligned means the low TILE_LOG2 bits of both x and y are zero.
  - On a tick_en while aligned, the new direction is move_direction if it is exactly one-hot, else 0000 (stop). The step below uses this new direction in the same cycle.
  - On a tick_en while not aligned, move_direction is ignored and curr_direction is held.
  - Step: RIGHT x+1, LEFT x-1, UP y-1, DOWN y+1; 0000 gives no move.
  - Wrap-around: LEFT at x == X_MIN gives x <= X_MAX; RIGHT at x == X_MAX gives x <= X_MIN. No y wrap.
- Collision (ROAM only, evaluated every clk when pause == 0):
  - Uses unsigned absolute differences on the current registered positions: dx 11-bit, dy 10-bit.
  - hit = (dx < HIT_DIST) & (dy < HIT_DIST).
  - On hit:
    - caught <= 1 for exactly one cycle.
    - Position <= START, curr_direction <= 0000, counter <= 0.
    - ghost_active <= 0, state <= HOME_WAIT.
  - Hit has priority over a simultaneous tick_en step.
  - caught is forced to 0 in all other cycles and states.
- Pause: the counter, position and state hold; collision is suppressed; move_tick pulses during pause are lost, not queued.
- rst has priority over every other event.

Test Plan:
- Reset then 119 ticks -> state HOME_WAIT, pos (320,240), dir 0000. Tick 120 -> next cycle dir UP, state EXIT_PEN.
- Continue 32 ticks -> y 240..208, then state ROAM, dir LEFT, ghost_active 1, x still 320.
- In ROAM at (320,208) with move_direction=DOWN -> DOWN latched, y=209. Change move_direction to RIGHT for the next 15 ticks -> DOWN held until y=224, where RIGHT is latched.
- Ghost at (0,224) heading LEFT, aligned, move_direction=LEFT, one tick -> x=624. Mirror case: RIGHT at 624 -> x=0.
- Pacman at (ghost_x+7, ghost_y) -> caught pulses 1 cycle, pos (320,240), state HOME_WAIT, active 0. Pacman at +8 on x -> no caught.
- move_direction=0110 at aligned tick -> dir 0000, no move. Assert pause with 5 ticks -> pos and counter unchanged. rst asserted during EXIT_PEN -> reset values the next cycle.
